// File: rtl/ej32_divider_if.sv
// Handshake and operand/result bundle between the eJ32 arithmetic unit and its divider.
// The AU side uses the master modport; the divider uses the slave modport.
interface ej32_divider_if #(
    parameter int DSZ = 32
);
    logic           start;
    logic [DSZ-1:0] x;
    logic [DSZ-1:0] y;
    logic           busy;
    logic           done;
    logic           z;
    logic [DSZ-1:0] q;
    logic [DSZ-1:0] r;

    modport master (
        output start, x, y,
        input  busy, done, z, q, r
    );

    modport slave (
        input  start, x, y,
        output busy, done, z, q, r
    );
endinterface

// File: rtl/ej32_divider.sv
// Sequential radix-2 restoring signed divider (Java idiv/irem semantics).
// Produces one quotient bit per clock on the magnitudes, then fixes signs in a final step.
module ej32_divider #(
    parameter int DSZ = 32,
    parameter int CW  = $clog2(DSZ + 1)
) (
    input  logic              clk,
    input  logic              rst,
    ej32_divider_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

    localparam logic [DSZ-1:0] ZERO_C    = {DSZ{1'b0}};
    localparam logic [DSZ-1:0] ONE_C     = {{(DSZ-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_ONE_C = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_INI_C = CW'(DSZ);

    // Two's-complement negation, truncated to DSZ bits.
    function automatic logic [DSZ-1:0] neg_f(input logic [DSZ-1:0] v);
        return ~v + ONE_C;
    endfunction

    // Magnitude of a signed operand; MIN_INT maps onto its unsigned value 2^(DSZ-1).
    function automatic logic [DSZ-1:0] abs_f(input logic [DSZ-1:0] v);
        if (v[DSZ-1]) begin
            return neg_f(v);
        end else begin
            return v;
        end
    endfunction

    state_t         state_r, state_s;
    logic [DSZ-1:0] dvd_r,   dvd_s;
    logic [DSZ-1:0] dvs_r,   dvs_s;
    logic [DSZ:0]   rem_r,   rem_s;
    logic [CW-1:0]  cnt_r,   cnt_s;
    logic           sq_r,    sq_s;
    logic           sr_r,    sr_s;
    logic           busy_r,  busy_s;
    logic           done_r,  done_s;
    logic           z_r,     z_s;
    logic [DSZ-1:0] q_r,     q_s;
    logic [DSZ-1:0] r_r,     r_s;

    logic [DSZ:0]   rem_sh_s;
    logic [DSZ:0]   rem_diff_s;
    logic           rem_ge_s;
    logic           rem_msb_unused_s;

    // The partial remainder never reaches 2^DSZ after a restoring step, so its MSB only matters
    // transiently inside the shifted trial value.
    assign rem_sh_s         = {rem_r[DSZ-1:0], dvd_r[DSZ-1]};
    assign rem_diff_s       = rem_sh_s - {1'b0, dvs_r};
    assign rem_ge_s         = (rem_sh_s >= {1'b0, dvs_r});
    assign rem_msb_unused_s = rem_r[DSZ];

    // Next-state and next-datapath logic for the IDLE/CALC/SIGN sequencer.
    always_comb begin
        state_s = state_r;
        dvd_s   = dvd_r;
        dvs_s   = dvs_r;
        rem_s   = rem_r;
        cnt_s   = cnt_r;
        sq_s    = sq_r;
        sr_s    = sr_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        z_s     = z_r;
        q_s     = q_r;
        r_s     = r_r;

        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    if (bus.y == ZERO_C) begin
                        q_s     = ZERO_C;
                        r_s     = bus.x;
                        z_s     = 1'b1;
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                        state_s = IDLE;
                    end else begin
                        dvd_s   = abs_f(bus.x);
                        dvs_s   = abs_f(bus.y);
                        rem_s   = {(DSZ+1){1'b0}};
                        cnt_s   = CNT_INI_C;
                        sq_s    = bus.x[DSZ-1] ^ bus.y[DSZ-1];
                        sr_s    = bus.x[DSZ-1];
                        busy_s  = 1'b1;
                        state_s = CALC;
                    end
                end else begin
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end
            end

            CALC: begin
                if (rem_ge_s) begin
                    rem_s = rem_diff_s;
                    dvd_s = {dvd_r[DSZ-2:0], 1'b1};
                end else begin
                    rem_s = rem_sh_s;
                    dvd_s = {dvd_r[DSZ-2:0], 1'b0};
                end
                cnt_s  = cnt_r - CNT_ONE_C;
                busy_s = 1'b1;
                if (cnt_r == CNT_ONE_C) begin
                    state_s = SIGN;
                end else begin
                    state_s = CALC;
                end
            end

            SIGN: begin
                if (sq_r) begin
                    q_s = neg_f(dvd_r);
                end else begin
                    q_s = dvd_r;
                end
                if (sr_r) begin
                    r_s = neg_f(rem_r[DSZ-1:0]);
                end else begin
                    r_s = rem_r[DSZ-1:0];
                end
                z_s     = 1'b0;
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = IDLE;
            end

            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_r  <= {DSZ{1'b0}};
            dvs_r  <= {DSZ{1'b0}};
            rem_r  <= {(DSZ+1){1'b0}};
            cnt_r  <= {CW{1'b0}};
            sq_r   <= 1'b0;
            sr_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            z_r    <= 1'b0;
            q_r    <= {DSZ{1'b0}};
            r_r    <= {DSZ{1'b0}};
        end else begin
            dvd_r  <= dvd_s;
            dvs_r  <= dvs_s;
            rem_r  <= rem_s;
            cnt_r  <= cnt_s;
            sq_r   <= sq_s;
            sr_r   <= sr_s;
            busy_r <= busy_s;
            done_r <= done_s;
            z_r    <= z_s;
            q_r    <= q_s;
            r_r    <= r_s;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.z    = z_r;
    assign bus.q    = q_r;
    assign bus.r    = r_r;

endmodule
